// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - framebuffer geometry defaults, address width helper and pixel queue entry type
package fb_pkg;

  localparam int FB_WIDTH_DEF  = 320;
  localparam int FB_HEIGHT_DEF = 240;
  localparam int COLRW_DEF     = 4;

  function automatic int fb_addrw(input int w, input int h);
    return $clog2(w * h);
  endfunction

  localparam int ADDRW_DEF = fb_addrw(FB_WIDTH_DEF, FB_HEIGHT_DEF);

  typedef struct packed {
    logic [ADDRW_DEF-1:0] addr;
    logic [COLRW_DEF-1:0] colr;
  } pix_t;

endpackage

// File: rtl/pix_fifo.sv
// rtl/pix_fifo.sv - first-word-fall-through synchronous FIFO of pixel entries
module pix_fifo
  import fb_pkg::*;
#(
  parameter type T     = pix_t,
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  T            din,
  input  logic        pop,
  output T            dout,
  output logic        full,
  output logic        empty,
  output logic [PW:0] count
);

  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A push into a full queue only lands when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/draw_fb_writer.sv
// rtl/draw_fb_writer.sv - clips engine pixels, linearises them and queues them to a framebuffer write port
module draw_fb_writer
  import fb_pkg::*;
#(
  parameter int CORDW      = 10,
  parameter int COLRW      = COLRW_DEF,
  parameter int FB_WIDTH   = FB_WIDTH_DEF,
  parameter int FB_HEIGHT  = FB_HEIGHT_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDRW      = fb_addrw(FB_WIDTH, FB_HEIGHT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [COLRW-1:0] colr,
  input  logic [CORDW-1:0] x,
  input  logic [CORDW-1:0] y,
  input  logic             drawing,
  input  logic             shape_done,
  output logic             oe,
  output logic             fb_we,
  output logic [ADDRW-1:0] fb_addr,
  output logic [COLRW-1:0] fb_colr,
  input  logic             fb_ready,
  output logic             busy,
  output logic             done,
  output logic [15:0]      clip_cnt,
  output logic             overflow
);

  typedef struct packed {
    logic [ADDRW-1:0] addr;
    logic [COLRW-1:0] colr;
  } entry_t;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          clip;
  logic          take;
  logic [ADDRW-1:0] lin_addr;
  logic          stage_valid;
  entry_t        stage_pix;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  entry_t        head;
  logic          pop;
  logic          push_ok;
  logic          pending;
  int            occ_next;
  int            stage_next;

  assign clip     = (32'(x) >= FB_WIDTH) || (32'(y) >= FB_HEIGHT);
  assign take     = drawing && !clip;
  assign lin_addr = ADDRW'(y) * ADDRW'(FB_WIDTH) + ADDRW'(x);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage_pix   <= '0;
      clip_cnt    <= '0;
    end else begin
      stage_valid <= take;
      if (take) begin
        stage_pix.addr <= lin_addr;
        stage_pix.colr <= colr;
      end
      if (drawing && clip && clip_cnt != 16'hFFFF) clip_cnt <= clip_cnt + 16'd1;
    end
  end

  pix_fifo #(
    .T     (entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (stage_valid),
    .din   (stage_pix),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign fb_we   = !fifo_empty;
  assign fb_addr = fifo_empty ? '0 : head.addr;
  assign fb_colr = fifo_empty ? '0 : head.colr;
  assign pop     = fb_we && fb_ready;
  assign push_ok = stage_valid && (!fifo_full || pop);

  // Throttle on what the queue will hold next cycle, leaving one slot of skid.
  always_comb begin
    occ_next   = int'(fifo_count) + (push_ok ? 1 : 0) - (pop ? 1 : 0);
    stage_next = take ? 1 : 0;
  end

  assign done = pending && !stage_valid && fifo_empty;
  assign busy = pending || stage_valid || !fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oe       <= 1'b0;
      overflow <= 1'b0;
      pending  <= 1'b0;
    end else begin
      oe <= (occ_next + stage_next) <= (FIFO_DEPTH - 2);
      if (stage_valid && fifo_full && !pop) overflow <= 1'b1;
      if (done)            pending <= 1'b0;
      else if (shape_done) pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_draw_fb_writer.sv
// tb/tb_draw_fb_writer.sv - directed self-checking bench for draw_fb_writer
module tb_draw_fb_writer;

  localparam int CORDW = 10;
  localparam int COLRW = 4;
  localparam int ADDRW = 17;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [COLRW-1:0] colr = '0;
  logic [CORDW-1:0] x = '0;
  logic [CORDW-1:0] y = '0;
  logic             drawing = 1'b0;
  logic             shape_done = 1'b0;
  logic             fb_ready = 1'b1;
  logic             oe;
  logic             fb_we;
  logic [ADDRW-1:0] fb_addr;
  logic [COLRW-1:0] fb_colr;
  logic             busy;
  logic             done;
  logic [15:0]      clip_cnt;
  logic             overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int wa[$];
  int wc[$];
  int done_cnt = 0;
  int cyc = 0;
  int last_wr_cyc = -1;
  int done_cyc = -1;
  int sx[16];
  int sy[16];
  int sc[16];
  int sent;

  always #5 clk = ~clk;

  draw_fb_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .colr       (colr),
    .x          (x),
    .y          (y),
    .drawing    (drawing),
    .shape_done (shape_done),
    .oe         (oe),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_colr    (fb_colr),
    .fb_ready   (fb_ready),
    .busy       (busy),
    .done       (done),
    .clip_cnt   (clip_cnt),
    .overflow   (overflow)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sampled after the driver has settled its inputs, so it predicts the next edge.
  always @(negedge clk) begin
    #2;
    cyc++;
    if (fb_we && fb_ready) begin
      wa.push_back(int'(fb_addr));
      wc.push_back(int'(fb_colr));
      last_wr_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic clear_log();
    wa.delete();
    wc.delete();
    done_cnt = 0;
    done_cyc = -1;
    last_wr_cyc = -1;
  endtask

  task automatic idle(input int n);
    drawing = 1'b0;
    shape_done = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic run_shape(input int n, input bit obey, input bit rnd, input bit with_done, input int max_cyc);
    int guard = 0;
    while (sent < n && guard < max_cyc) begin
      if (rnd) fb_ready = 1'($urandom_range(0, 1));
      if (!obey || oe) begin
        x = CORDW'(sx[sent]);
        y = CORDW'(sy[sent]);
        colr = COLRW'(sc[sent]);
        drawing = 1'b1;
        shape_done = with_done && (sent == n - 1);
        sent++;
      end else begin
        drawing = 1'b0;
        shape_done = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    drawing = 1'b0;
    shape_done = 1'b0;
  endtask

  task automatic wait_writes(input string tag, input int n, input int limit, input bit rnd);
    int guard = 0;
    while (wa.size() < n && guard < limit) begin
      if (rnd) fb_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      guard++;
    end
    check(tag, wa.size(), n);
  endtask

  function automatic int wr_at(input int i);
    return (i < wa.size()) ? wa[i] : -1;
  endfunction

  initial begin
    int exp_rect[10];
    exp_rect = '{0, 1, 2, 3, 640, 641, 642, 643, 320, 323};

    repeat (3) @(negedge clk);
    check("rst_oe", oe, 0);
    check("rst_fb_we", fb_we, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_colr", fb_colr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_clip_cnt", clip_cnt, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_oe", oe, 1);

    // single pixel, shape_done alongside it
    clear_log();
    x = 10'd5; y = 10'd2; colr = 4'd3; drawing = 1'b1; shape_done = 1'b1;
    @(negedge clk);
    drawing = 1'b0; shape_done = 1'b0;
    check("one_we_t1", fb_we, 0);
    @(negedge clk);
    check("one_we_t2", fb_we, 1);
    check("one_addr", fb_addr, 645);
    check("one_colr", fb_colr, 3);
    check("one_done_early", done, 0);
    check("one_busy", busy, 1);
    @(negedge clk);
    check("one_we_after", fb_we, 0);
    check("one_done", done, 1);
    @(negedge clk);
    check("one_done_pulse", done, 0);
    check("one_busy_after", busy, 0);

    // clipping at the right and bottom edges, last pixel is the corner
    clear_log();
    sx[0] = 320; sy[0] = 0;   sc[0] = 1;
    sx[1] = 0;   sy[1] = 240; sc[1] = 2;
    sx[2] = 319; sy[2] = 239; sc[2] = 9;
    sent = 0;
    run_shape(3, 0, 0, 1, 10);
    idle(6);
    check("clip_nwr", wa.size(), 1);
    check("clip_addr", wr_at(0), 76799);
    check("clip_colr", (wc.size() > 0) ? wc[0] : -1, 9);
    check("clip_cnt", clip_cnt, 2);
    check("clip_done_cnt", done_cnt, 1);

    // everything clipped: done one cycle after shape_done
    clear_log();
    x = 10'd400; y = 10'd10; drawing = 1'b1; shape_done = 1'b1;
    @(negedge clk);
    drawing = 1'b0; shape_done = 1'b0;
    check("allclip_done", done, 1);
    check("allclip_cnt", clip_cnt, 3);
    @(negedge clk);
    check("allclip_done_pulse", done, 0);
    check("allclip_nwr", wa.size(), 0);

    // backpressure with an engine that obeys oe
    clear_log();
    fb_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sx[i] = i; sy[i] = 1; sc[i] = (i + 2) % 16;
    end
    sent = 0;
    run_shape(10, 1, 0, 0, 8);
    check("bp_accepted", sent, 3);
    check("bp_oe_low", oe, 0);
    check("bp_nwr_stall", wa.size(), 0);
    check("bp_overflow", overflow, 0);
    fb_ready = 1'b1;
    run_shape(10, 1, 0, 0, 100);
    wait_writes("bp_nwr", 10, 100, 0);
    idle(3);
    check("bp_nwr_final", wa.size(), 10);
    for (int i = 0; i < 10; i++) check($sformatf("bp_addr%0d", i), wr_at(i), 320 + i);
    check("bp_overflow_end", overflow, 0);

    // forced drawing into a full queue
    clear_log();
    fb_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sx[i] = 10 + i; sy[i] = 0; sc[i] = i;
    end
    sent = 0;
    run_shape(6, 0, 0, 0, 6);
    idle(2);
    check("ovf_set", overflow, 1);
    check("ovf_nwr_stall", wa.size(), 0);
    fb_ready = 1'b1;
    wait_writes("ovf_nwr", 4, 50, 0);
    idle(3);
    check("ovf_nwr_final", wa.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("ovf_addr%0d", i), wr_at(i), 10 + i);
    check("ovf_sticky", overflow, 1);

    // rectangle (0,0)-(3,2) perimeter with random fb_ready
    clear_log();
    for (int i = 0; i < 4; i++) begin
      sx[i] = i;     sy[i] = 0;     sc[i] = 5;
      sx[i + 4] = i; sy[i + 4] = 2; sc[i + 4] = 6;
    end
    sx[8] = 0; sy[8] = 1; sc[8] = 7;
    sx[9] = 3; sy[9] = 1; sc[9] = 7;
    sent = 0;
    run_shape(10, 1, 1, 1, 500);
    wait_writes("rect_nwr", 10, 500, 1);
    fb_ready = 1'b1;
    idle(3);
    for (int i = 0; i < 10; i++) check($sformatf("rect_addr%0d", i), wr_at(i), exp_rect[i]);
    check("rect_done_cnt", done_cnt, 1);
    check("rect_done_cyc", done_cyc, last_wr_cyc + 1);
    check("rect_busy_after", busy, 0);

    // reset with three pixels queued and a shape pending
    clear_log();
    fb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sx[i] = 20 + i; sy[i] = 3; sc[i] = 1;
    end
    sent = 0;
    run_shape(3, 0, 0, 1, 3);
    idle(2);
    check("mid_busy_pre", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_fb_we", fb_we, 0);
    check("mid_oe", oe, 0);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    rst_n = 1'b1;
    fb_ready = 1'b1;
    @(negedge clk);
    check("mid_oe_rel", oe, 1);
    idle(5);
    check("mid_done_cnt", done_cnt, 0);
    check("mid_nwr", wa.size(), 0);
    check("mid_overflow", overflow, 0);
    check("mid_clip_cnt", clip_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
